// File: rtl/instr_asm_pkg.sv
// Shared types for the RV32I instruction assembler: immediate formats, error causes
// and the write-pointer step.
package instr_asm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_R   = 3'b011,
    IMM_J   = 3'b100,
    IMM_U   = 3'b101,
    IMM_IZ  = 3'b110,
    IMM_ILL = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_code_e;

  localparam int unsigned INSTR_STEP = 4;

  // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed field ending at lsb.
  function automatic logic upper_uniform(input logic [31:0] v, input logic [4:0] lsb);
    logic [31:0] top_s;
    top_s = 32'($signed(v) >>> lsb);
    return (top_s == 32'h0000_0000) || (top_s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_asm_range_check.sv
// Combinational legality check of an immediate against its encoding format;
// misalignment outranks a range violation.
module imm_range_check
  import instr_asm_pkg::*;
(
  input  imm_src_e    imm_src,
  input  logic [31:0] imm,
  output logic        ok,
  output err_code_e   err_code
);

  logic range_ok_s;
  logic misalign_s;
  logic illegal_s;

  // Per-format representability and alignment
  always_comb begin
    range_ok_s = 1'b1;
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (imm_src)
      IMM_I, IMM_S: range_ok_s = upper_uniform(imm, 5'd11);
      IMM_IZ:       range_ok_s = (imm[31:12] == 20'h0_0000);
      IMM_B: begin
        range_ok_s = upper_uniform(imm, 5'd12);
        misalign_s = imm[0];
      end
      IMM_J: begin
        range_ok_s = upper_uniform(imm, 5'd20);
        misalign_s = imm[0];
      end
      IMM_U:        range_ok_s = (imm[11:0] == 12'h000);
      IMM_R:        range_ok_s = 1'b1;
      default:      illegal_s  = 1'b1;
    endcase
  end

  // Collapse the individual findings into a single verdict
  always_comb begin
    if (illegal_s) begin
      ok       = 1'b0;
      err_code = ERR_ILLEGAL;
    end else if (misalign_s) begin
      ok       = 1'b0;
      err_code = ERR_MISALIGN;
    end else if (!range_ok_s) begin
      ok       = 1'b0;
      err_code = ERR_RANGE;
    end else begin
      ok       = 1'b1;
      err_code = ERR_NONE;
    end
  end

endmodule

// File: rtl/instr_assembler.sv
// Packs opcode, register fields and an immediate into an RV32I word and streams it to
// instruction memory through a two-stage (check, pack) valid/ready pipeline.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               imm_src,
  input  logic [31:0]              imm,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     load_base,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [31:0]              wr_data,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  logic        s1_valid_r, s1_ok_r;
  imm_src_e    s1_src_r;
  err_code_e   s1_code_r;
  logic [31:0] s1_imm_r;
  logic [6:0]  s1_opcode_r, s1_funct7_r;
  logic [4:0]  s1_rd_r, s1_rs1_r, s1_rs2_r;
  logic [2:0]  s1_funct3_r;

  logic        chk_ok_s;
  err_code_e   chk_code_s;
  logic        s2_adv_s, accept_s;
  logic [31:0] packed_s;
  logic [ADDRESS_WIDTH-1:0] base_aligned_s;
  logic        unused_base_s;

  assign s2_adv_s       = !out_valid || out_ready;
  assign in_ready       = rst_n && !load_base && (!s1_valid_r || s2_adv_s);
  assign accept_s       = in_valid && in_ready;
  assign busy           = s1_valid_r || out_valid;
  assign base_aligned_s = {base_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_base_s  = ^base_addr[1:0];

  imm_range_check u_range_check (
    .imm_src  (imm_src_e'(imm_src)),
    .imm      (imm),
    .ok       (chk_ok_s),
    .err_code (chk_code_s)
  );

  // S1: capture an accepted request together with its range-check verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_ok_r     <= 1'b0;
      s1_src_r    <= IMM_I;
      s1_code_r   <= ERR_NONE;
      s1_imm_r    <= 32'h0;
      s1_opcode_r <= 7'h0;
      s1_funct7_r <= 7'h0;
      s1_rd_r     <= 5'h0;
      s1_rs1_r    <= 5'h0;
      s1_rs2_r    <= 5'h0;
      s1_funct3_r <= 3'h0;
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      s1_ok_r     <= chk_ok_s;
      s1_src_r    <= imm_src_e'(imm_src);
      s1_code_r   <= chk_code_s;
      s1_imm_r    <= imm;
      s1_opcode_r <= opcode;
      s1_funct7_r <= funct7;
      s1_rd_r     <= rd;
      s1_rs1_r    <= rs1;
      s1_rs2_r    <= rs2;
      s1_funct3_r <= funct3;
    end else if (s2_adv_s) begin
      s1_valid_r  <= 1'b0;
    end else begin
      s1_valid_r  <= s1_valid_r;
    end
  end

  // Field scatter for every encodable format
  always_comb begin
    packed_s = 32'h0;
    case (s1_src_r)
      IMM_I, IMM_IZ: packed_s = {s1_imm_r[11:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
      IMM_S: packed_s = {s1_imm_r[11:5], s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_imm_r[4:0], s1_opcode_r};
      IMM_B: packed_s = {s1_imm_r[12], s1_imm_r[10:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                         s1_imm_r[4:1], s1_imm_r[11], s1_opcode_r};
      IMM_J: packed_s = {s1_imm_r[20], s1_imm_r[10:1], s1_imm_r[11], s1_imm_r[19:12],
                         s1_rd_r, s1_opcode_r};
      IMM_U: packed_s = {s1_imm_r[31:12], s1_rd_r, s1_opcode_r};
      IMM_R: packed_s = {s1_funct7_r, s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
      default: packed_s = 32'h0;
    endcase
  end

  // S2: packed word for memory; a rejected request leaves a bubble and the old data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wr_data   <= 32'h0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r && s1_ok_r;
      wr_data   <= (s1_valid_r && s1_ok_r) ? packed_s : wr_data;
    end else begin
      out_valid <= out_valid;
      wr_data   <= wr_data;
    end
  end

  // Write pointer: steps per completed write, reloadable only while the pipe is empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= {ADDRESS_WIDTH{1'b0}};
    end else if (out_valid && out_ready) begin
      wr_addr <= wr_addr + ADDRESS_WIDTH'(INSTR_STEP);
    end else if (load_base && !busy) begin
      wr_addr <= base_aligned_s;
    end else begin
      wr_addr <= wr_addr;
    end
  end

  // Drop accounting: saturating count, first cause kept sticky
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= 2'b00;
      err_cnt  <= {ERR_CNT_W{1'b0}};
    end else if (s1_valid_r && !s1_ok_r && s2_adv_s) begin
      err      <= 1'b1;
      err_code <= err ? err_code : s1_code_r;
      err_cnt  <= (err_cnt == {ERR_CNT_W{1'b1}}) ? err_cnt
                                                 : err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err      <= err;
      err_code <= err_code;
      err_cnt  <= err_cnt;
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed encoding/flow cases plus randomized
// traffic scored against a format-level reference model.
module tb_instr_assembler;

  logic        clk, rst_n, in_valid, in_ready, load_base, out_valid, out_ready, busy, err;
  logic [2:0]  imm_src, funct3;
  logic [31:0] imm, base_addr, wr_addr, wr_data;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_ptr;
  int          exp_drops;
  int          exp_first;

  instr_assembler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .load_base(load_base), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference: 0 ok, 1 range, 2 misaligned, 3 illegal -- from the signed value range of each field
  function automatic int ref_code(input logic [2:0] src, input logic [31:0] v);
    int s;
    s = $signed(v);
    case (src)
      3'b000, 3'b001: return (s >= -2048 && s <= 2047) ? 0 : 1;
      3'b110:         return (v <= 32'd4095) ? 0 : 1;
      3'b010:         return v[0] ? 2 : ((s >= -4096 && s <= 4095) ? 0 : 1);
      3'b100:         return v[0] ? 2 : ((s >= -1048576 && s <= 1048575) ? 0 : 1);
      3'b101:         return ((v % 32'd4096) == 32'd0) ? 0 : 1;
      3'b011:         return 0;
      default:        return 3;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] src, input logic [31:0] i,
                                           input logic [6:0] op, input logic [4:0] d,
                                           input logic [4:0] a, input logic [4:0] b,
                                           input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] regs;
    regs = (32'(b) << 20) | (32'(a) << 15) | (32'(f3) << 12);
    case (src)
      3'b000, 3'b110: return ((i & 32'hFFF) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
      3'b001: return (((i >> 5) & 32'h7F) << 25) | regs | ((i & 32'h1F) << 7) | 32'(op);
      3'b010: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | regs
                     | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'(op);
      3'b100: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                     | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
      3'b101: return (i & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      default: return (32'(f7) << 25) | regs | (32'(d) << 7) | 32'(op);
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_ptr   = 32'h0;
    exp_drops = 0;
    exp_first = 0;
  endtask

  task automatic check_outputs();
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_write", 32'(out_valid), 32'h0);
      else begin
        check("wr_data", wr_data, exp_q[0]);
        check("wr_addr", wr_addr, exp_ptr);
      end
    end
  endtask

  // One cycle: settle inputs, book handshakes in the model, then check outputs at the falling edge
  task automatic step();
    int c;
    #1;
    if (in_valid && in_ready) begin
      c = ref_code(imm_src, imm);
      if (c == 0) exp_q.push_back(ref_word(imm_src, imm, opcode, rd, rs1, rs2, funct3, funct7));
      else begin
        if (exp_drops < 255) exp_drops++;
        if (exp_first == 0) exp_first = c;
      end
    end
    if (out_valid && out_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ptr = exp_ptr + 32'd4;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input logic [2:0] src, input logic [31:0] i, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                         input logic [2:0] f3, input logic [6:0] f7);
    in_valid = 1'b1; imm_src = src; imm = i; opcode = op;
    rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) step();
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
    step(); step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; load_base = 1'b0; out_ready = 1'b1; base_addr = 32'h0;
    set_req(3'b000, 32'h0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_wr_addr",   wr_addr, 32'h0);
    check("rst_wr_data",   wr_data, 32'h0);
    check("rst_err",       32'(err), 32'h0);
    check("rst_err_code",  32'(err_code), 32'h0);
    check("rst_err_cnt",   32'(err_cnt), 32'h0);
    check("rst_in_ready",  32'(in_ready), 32'h0);
    rst_n = 1'b1;

    load_base = 1'b1; base_addr = 32'h100;
    step();
    exp_ptr = 32'h100; load_base = 1'b0;
    check("load_base", wr_addr, 32'h100);

    // I-sext addi x1,x0,5 with two-cycle latency
    set_req(3'b000, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    step(); in_valid = 1'b0; step();
    check("lat_valid", 32'(out_valid), 32'h1);
    check("i_word", wr_data, 32'h0050_0093);
    check("i_addr", wr_addr, 32'h100);
    step();

    // S then B back to back
    set_req(3'b001, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0);
    step();
    set_req(3'b010, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0);
    step(); in_valid = 1'b0;
    check("s_word", wr_data, 32'h0020_A423);
    check("s_addr", wr_addr, 32'h104);
    step();
    check("b_word", wr_data, 32'hFE00_0EE3);
    check("b_addr", wr_addr, 32'h108);
    step();

    // J and U under back-pressure
    out_ready = 1'b0;
    set_req(3'b100, 32'h800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    step();
    set_req(3'b101, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0);
    step(); in_valid = 1'b0;
    #1 check("stall_in_ready", 32'(in_ready), 32'h0);
    check("j_word", wr_data, 32'h0010_00EF);
    for (int k = 0; k < 2; k++) begin
      step();
      check("j_hold_valid", 32'(out_valid), 32'h1);
      check("j_hold_word", wr_data, 32'h0010_00EF);
      check("j_hold_addr", wr_addr, 32'h10C);
    end
    out_ready = 1'b1;
    step();
    check("u_word", wr_data, 32'h1234_52B7);
    check("u_addr", wr_addr, 32'h110);
    drain();

    // Rejected requests: range, misaligned, illegal
    set_req(3'b000, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0); step();
    set_req(3'b010, 32'd3,    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0); step();
    set_req(3'b111, 32'd0,    7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0); step();
    drain();
    check("err_flag", 32'(err), 32'h1);
    check("err_code_first", 32'(err_code), 32'h1);
    check("err_cnt3", 32'(err_cnt), 32'd3);
    check("err_addr_same", wr_addr, 32'h114);
    check("idle_busy", 32'(busy), 32'h0);

    // load_base while busy is ignored
    set_req(3'b011, 32'h0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20);
    step(); in_valid = 1'b0;
    load_base = 1'b1; base_addr = 32'h40;
    #1 check("lb_busy", 32'(busy), 32'h1);
    check("lb_in_ready", 32'(in_ready), 32'h0);
    step(); load_base = 1'b0;
    drain();
    check("lb_ignored", wr_addr, 32'h118);

    // Wrap past the top of the address space; low base bits are dropped
    load_base = 1'b1; base_addr = 32'hFFFF_FFFE;
    step();
    load_base = 1'b0; exp_ptr = 32'hFFFF_FFFC;
    check("wrap_base", wr_addr, 32'hFFFF_FFFC);
    set_req(3'b101, 32'hABCD_E000, 7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 7'h0); step();
    set_req(3'b110, 32'h0000_0FFF, 7'h13, 5'd2, 5'd3, 5'd0, 3'd7, 7'h0); step();
    in_valid = 1'b0;
    check("wrap_a0", wr_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_a1", wr_addr, 32'h0);
    drain();

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       imm = r;
        1:       imm = {{20{r[11]}}, r[11:0]};
        2:       imm = {{12{r[19]}}, r[19:1], 1'b0};
        default: imm = {r[31:12], 12'h000};
      endcase
      in_valid  = ($urandom_range(0, 99) < 65);
      imm_src   = 3'($urandom_range(0, 7));
      opcode    = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3    = 3'($urandom); funct7 = 7'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain();
    check("rand_err_cnt", 32'(err_cnt), 32'(exp_drops));
    check("rand_err_code", 32'(err_code), 32'(exp_first));

    // Reset with two requests in flight
    out_ready = 1'b0;
    set_req(3'b000, 32'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'h0); step();
    set_req(3'b001, 32'd4, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0); step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_addr", wr_addr, 32'h0);
    check("mid_rst_cnt", 32'(err_cnt), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    model_reset();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("post_rst_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
